// File: rtl/xbar_peri_demux.sv
// ---------------------------------------------------------------------------
// xbar_peri_demux
//
// 1-to-N TileLink-UL crossbar for the 24 MHz peripheral domain. Channel A
// from the CDC adapter is routed to one of NUM_SLAVES peripherals by address
// decode. Channel D is returned from whichever slave currently owns the
// outstanding requests. Accesses that hit no slave are answered by a small
// internal error responder.
//
// Only one target may have requests in flight at a time. This keeps
// responses from ever being reordered across slaves.
//
// Ports
//   clk, reset        : clock and asynchronous active-low reset
//   a_*               : master-side Channel A (a_ready is an output)
//   d_*               : master-side Channel D (d_ready is an input)
//   a_valid_out       : per-slave A valid
//   a_ready_out       : per-slave A ready
//   a_*_out           : A payload, broadcast to every slave
//   d_valid_in        : per-slave D valid
//   d_ready_in        : per-slave D ready
//   d_*_in            : flat per-slave D payloads; slave i sits at slice i
//   err_count         : saturating count of accepted unmapped requests
// ---------------------------------------------------------------------------
module xbar_peri_demux #(
  parameter int NUM_SLAVES      = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MASK_WIDTH      = DATA_WIDTH / 8,
  parameter int SIZE_WIDTH      = 3,
  parameter int SRC_WIDTH       = 2,
  parameter int SINK_WIDTH      = 1,
  parameter int OPCODE_WIDTH    = 3,
  parameter int PARAM_WIDTH     = 3,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
    {32'h1000_3000, 32'h1000_2000, 32'h1000_1000, 32'h1000_0000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK =
    {NUM_SLAVES{32'hFFFF_F000}},
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  // master-side Channel A
  input  logic                               a_valid,
  output logic                               a_ready,
  input  logic [OPCODE_WIDTH-1:0]            a_opcode,
  input  logic [PARAM_WIDTH-1:0]             a_param,
  input  logic [SIZE_WIDTH-1:0]              a_size,
  input  logic [SRC_WIDTH-1:0]               a_source,
  input  logic [ADDR_WIDTH-1:0]              a_address,
  input  logic [MASK_WIDTH-1:0]              a_mask,
  input  logic [DATA_WIDTH-1:0]              a_data,
  // master-side Channel D
  output logic                               d_valid,
  input  logic                               d_ready,
  output logic [OPCODE_WIDTH-1:0]            d_opcode,
  output logic [PARAM_WIDTH-1:0]             d_param,
  output logic [SIZE_WIDTH-1:0]              d_size,
  output logic [SRC_WIDTH-1:0]               d_source,
  output logic [SINK_WIDTH-1:0]              d_sink,
  output logic [DATA_WIDTH-1:0]              d_data,
  output logic                               d_error,
  // slave-side Channel A
  output logic [NUM_SLAVES-1:0]              a_valid_out,
  input  logic [NUM_SLAVES-1:0]              a_ready_out,
  output logic [OPCODE_WIDTH-1:0]            a_opcode_out,
  output logic [PARAM_WIDTH-1:0]             a_param_out,
  output logic [SIZE_WIDTH-1:0]              a_size_out,
  output logic [SRC_WIDTH-1:0]               a_source_out,
  output logic [ADDR_WIDTH-1:0]              a_address_out,
  output logic [MASK_WIDTH-1:0]              a_mask_out,
  output logic [DATA_WIDTH-1:0]              a_data_out,
  // slave-side Channel D
  input  logic [NUM_SLAVES-1:0]              d_valid_in,
  output logic [NUM_SLAVES-1:0]              d_ready_in,
  input  logic [NUM_SLAVES*OPCODE_WIDTH-1:0] d_opcode_in,
  input  logic [NUM_SLAVES*PARAM_WIDTH-1:0]  d_param_in,
  input  logic [NUM_SLAVES*SIZE_WIDTH-1:0]   d_size_in,
  input  logic [NUM_SLAVES*SRC_WIDTH-1:0]    d_source_in,
  input  logic [NUM_SLAVES*SINK_WIDTH-1:0]   d_sink_in,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0]   d_data_in,
  input  logic [NUM_SLAVES-1:0]              d_error_in,
  // status
  output logic [15:0]                        err_count
);

  // Target index NUM_SLAVES is the internal error responder.
  localparam int TGT_W = $clog2(NUM_SLAVES + 1);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [TGT_W-1:0] ERR_TGT  = TGT_W'(NUM_SLAVES);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [OPCODE_WIDTH-1:0] OP_GET            = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_ACCESS_ACK     = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_ACCESS_ACK_DAT = OPCODE_WIDTH'(1);

  logic [TGT_W-1:0]        cur_target;
  logic [CNT_W-1:0]        out_cnt;
  logic                    err_pending;
  logic [OPCODE_WIDTH-1:0] err_opcode;
  logic [SIZE_WIDTH-1:0]   err_size;
  logic [SRC_WIDTH-1:0]    err_source;

  logic [TGT_W-1:0]        dec_target;
  logic                    dec_is_err;
  logic                    out_busy;
  logic                    admit;
  logic                    d_valid_mux;
  logic                    a_fire;
  logic                    d_fire;

  // The A payload goes to every slave; only the valid is steered.
  assign a_opcode_out  = a_opcode;
  assign a_param_out   = a_param;
  assign a_size_out    = a_size;
  assign a_source_out  = a_source;
  assign a_address_out = a_address;
  assign a_mask_out    = a_mask;
  assign a_data_out    = a_data;

  // Address decode. Scanning from the top down lets the lowest hitting
  // index overwrite the others, so overlapping windows resolve to slave 0
  // first.
  always_comb begin
    dec_target = ERR_TGT;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((a_address & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        dec_target = TGT_W'(i);
      end
    end
  end

  assign dec_is_err = (dec_target == ERR_TGT);
  assign out_busy   = (out_cnt != '0);

  // Admission uses only registered state. A D fire in the same cycle
  // therefore cannot free a slot or switch targets until the next cycle.
  // Holding admission off during reset keeps a_ready low while reset is
  // asserted.
  assign admit = reset
               && (!out_busy || (dec_target == cur_target))
               && (out_cnt < CNT_MAX)
               && !(dec_is_err && err_pending);

  // Channel A steering. The error target always accepts once admitted.
  always_comb begin
    a_valid_out = '0;
    a_ready     = 1'b0;
    if (admit) begin
      if (dec_is_err) begin
        a_ready = 1'b1;
      end else begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
          if (dec_target == TGT_W'(i)) begin
            a_valid_out[i] = a_valid;
            a_ready        = a_ready_out[i];
          end
        end
      end
    end
  end

  // Channel D mux. With nothing outstanding, both valid and ready are
  // forced low, so stray valids from idle slaves never leak through.
  always_comb begin
    d_valid_mux = 1'b0;
    d_opcode    = '0;
    d_param     = '0;
    d_size      = '0;
    d_source    = '0;
    d_sink      = '0;
    d_data      = '0;
    d_error     = 1'b0;
    d_ready_in  = '0;
    if (cur_target == ERR_TGT) begin
      d_valid_mux = err_pending;
      d_opcode    = err_opcode;
      d_size      = err_size;
      d_source    = err_source;
      d_error     = 1'b1;
    end else begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (cur_target == TGT_W'(i)) begin
          d_valid_mux   = d_valid_in[i];
          d_opcode      = d_opcode_in[i*OPCODE_WIDTH +: OPCODE_WIDTH];
          d_param       = d_param_in[i*PARAM_WIDTH +: PARAM_WIDTH];
          d_size        = d_size_in[i*SIZE_WIDTH +: SIZE_WIDTH];
          d_source      = d_source_in[i*SRC_WIDTH +: SRC_WIDTH];
          d_sink        = d_sink_in[i*SINK_WIDTH +: SINK_WIDTH];
          d_data        = d_data_in[i*DATA_WIDTH +: DATA_WIDTH];
          d_error       = d_error_in[i];
          d_ready_in[i] = d_ready & out_busy;
        end
      end
    end
  end

  assign d_valid = d_valid_mux & out_busy;
  assign a_fire  = a_valid & a_ready;
  assign d_fire  = d_valid & d_ready;

  // Outstanding tracking: the target follows the most recent accepted
  // request. The counter nets A fires against D fires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_target <= '0;
      out_cnt    <= '0;
    end else begin
      if (a_fire) begin
        cur_target <= dec_target;
      end
      case ({a_fire, d_fire})
        2'b10:   out_cnt <= out_cnt + 1'b1;
        2'b01:   out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  // Error responder. Admission blocks a second unmapped request while one
  // is pending, so set and clear can never coincide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_pending <= 1'b0;
      err_opcode  <= '0;
      err_size    <= '0;
      err_source  <= '0;
      err_count   <= '0;
    end else begin
      if (a_fire && dec_is_err) begin
        err_pending <= 1'b1;
        err_opcode  <= (a_opcode == OP_GET) ? OP_ACCESS_ACK_DAT : OP_ACCESS_ACK;
        err_size    <= a_size;
        err_source  <= a_source;
        if (err_count != 16'hFFFF) begin
          err_count <= err_count + 16'd1;
        end
      end else if (d_fire && (cur_target == ERR_TGT)) begin
        err_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_xbar_peri_demux.sv
// ---------------------------------------------------------------------------
// tb_xbar_peri_demux
//
// Self-checking bench for xbar_peri_demux. A reference model tracks the
// in-flight requests as a queue of target indices. Each cycle, expected
// outputs are derived from that queue and the current inputs. Directed
// scenarios come first, followed by randomized traffic with occasional
// resets.
// ---------------------------------------------------------------------------
module tb_xbar_peri_demux;

  localparam int N    = 4;
  localparam int MAXO = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          a_valid, a_ready;
  logic [2:0]    a_opcode, a_param, a_size;
  logic [1:0]    a_source;
  logic [31:0]   a_address;
  logic [3:0]    a_mask;
  logic [31:0]   a_data;
  logic          d_valid, d_ready;
  logic [2:0]    d_opcode, d_param, d_size;
  logic [1:0]    d_source;
  logic [0:0]    d_sink;
  logic [31:0]   d_data;
  logic          d_error;
  logic [N-1:0]  a_valid_out, a_ready_out;
  logic [2:0]    a_opcode_out, a_param_out, a_size_out;
  logic [1:0]    a_source_out;
  logic [31:0]   a_address_out;
  logic [3:0]    a_mask_out;
  logic [31:0]   a_data_out;
  logic [N-1:0]  d_valid_in, d_ready_in;
  logic [N*3-1:0]  d_opcode_in, d_param_in, d_size_in;
  logic [N*2-1:0]  d_source_in;
  logic [N-1:0]    d_sink_in;
  logic [N*32-1:0] d_data_in;
  logic [N-1:0]    d_error_in;
  logic [15:0]     err_count;

  always #5 clk = ~clk;

  xbar_peri_demux #(.NUM_SLAVES(N), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_data(d_data),
    .d_error(d_error),
    .a_valid_out(a_valid_out), .a_ready_out(a_ready_out), .a_opcode_out(a_opcode_out),
    .a_param_out(a_param_out), .a_size_out(a_size_out), .a_source_out(a_source_out),
    .a_address_out(a_address_out), .a_mask_out(a_mask_out), .a_data_out(a_data_out),
    .d_valid_in(d_valid_in), .d_ready_in(d_ready_in), .d_opcode_in(d_opcode_in),
    .d_param_in(d_param_in), .d_size_in(d_size_in), .d_source_in(d_source_in),
    .d_sink_in(d_sink_in), .d_data_in(d_data_in), .d_error_in(d_error_in),
    .err_count(err_count)
  );

  // Slave address windows: slave i lives at 0x1000_i000, 4 KiB each.
  logic [31:0] base_tab [N] = '{32'h1000_0000, 32'h1000_1000, 32'h1000_2000, 32'h1000_3000};

  // Reference model: queue of targets of in-flight requests (N = error).
  int          tgt_q[$];
  logic [2:0]  m_err_op, m_err_size;
  logic [1:0]  m_err_src;
  int          m_err_cnt = 0;

  int checks = 0;
  int errors = 0;

  // Expected values for the current cycle.
  int          e_dec;
  logic        e_a_ready, e_d_valid, e_a_fire, e_d_fire, e_d_err;
  logic [N-1:0] e_avo, e_dri;
  logic [31:0] e_d_data;
  logic [2:0]  e_d_op, e_d_size, e_d_param;
  logic [1:0]  e_d_src;
  logic        e_d_sink;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int decode(input logic [31:0] addr);
    for (int i = 0; i < N; i++)
      if ((addr & 32'hFFFF_F000) == base_tab[i]) return i;
    return N;
  endfunction

  task automatic computeExpected();
    bit admit;
    bit err_busy;
    int t;
    e_dec    = decode(a_address);
    err_busy = (tgt_q.size() != 0) && (tgt_q[0] == N);
    admit    = ((tgt_q.size() == 0) || (tgt_q[0] == e_dec)) &&
               (tgt_q.size() < MAXO) && !(e_dec == N && err_busy);
    e_a_ready = 1'b0;
    e_avo     = '0;
    if (admit) begin
      if (e_dec == N) e_a_ready = 1'b1;
      else begin
        e_a_ready = a_ready_out[e_dec];
        e_avo[e_dec] = a_valid;
      end
    end
    e_d_valid = 1'b0; e_dri = '0; e_d_data = '0; e_d_op = '0; e_d_size = '0;
    e_d_param = '0; e_d_src = '0; e_d_sink = 1'b0; e_d_err = 1'b0;
    if (tgt_q.size() != 0) begin
      t = tgt_q[0];
      if (t < N) begin
        e_d_valid = d_valid_in[t];
        e_dri[t]  = d_ready;
        e_d_data  = d_data_in[t*32 +: 32];
        e_d_op    = d_opcode_in[t*3 +: 3];
        e_d_size  = d_size_in[t*3 +: 3];
        e_d_param = d_param_in[t*3 +: 3];
        e_d_src   = d_source_in[t*2 +: 2];
        e_d_sink  = d_sink_in[t];
        e_d_err   = d_error_in[t];
      end else begin
        e_d_valid = 1'b1;
        e_d_err   = 1'b1;
        e_d_op    = m_err_op;
        e_d_size  = m_err_size;
        e_d_src   = m_err_src;
      end
    end
    e_a_fire = a_valid & e_a_ready;
    e_d_fire = e_d_valid & d_ready;
  endtask

  task automatic updateModel();
    if (e_d_fire) void'(tgt_q.pop_front());
    if (e_a_fire) begin
      tgt_q.push_back(e_dec);
      if (e_dec == N) begin
        m_err_op   = (a_opcode == 3'd4) ? 3'd1 : 3'd0;
        m_err_size = a_size;
        m_err_src  = a_source;
        if (m_err_cnt < 65535) m_err_cnt++;
      end
    end
  endtask

  // Called at posedge+1: checks outputs mid-cycle, then advances one edge.
  task automatic stepCycle();
    #1;
    computeExpected();
    checkOutput("a_ready", a_ready, e_a_ready);
    checkOutput("a_valid_out", a_valid_out, e_avo);
    checkOutput("d_valid", d_valid, e_d_valid);
    checkOutput("d_ready_in", d_ready_in, e_dri);
    checkOutput("err_count", err_count, m_err_cnt);
    if (e_d_valid) begin
      checkOutput("d_data", d_data, e_d_data);
      checkOutput("d_error", d_error, e_d_err);
      checkOutput("d_opcode", d_opcode, e_d_op);
      checkOutput("d_source", d_source, e_d_src);
      checkOutput("d_size", d_size, e_d_size);
      checkOutput("d_param", d_param, e_d_param);
      checkOutput("d_sink", d_sink, e_d_sink);
    end
    @(posedge clk);
    updateModel();
    #1;
  endtask

  task automatic applyStimulus(input logic av, input logic [2:0] op, input logic [31:0] addr,
                               input logic [1:0] src, input logic [N-1:0] aro,
                               input logic [N-1:0] dvi, input logic dr);
    a_valid = av; a_opcode = op; a_address = addr; a_source = src;
    a_ready_out = aro; d_valid_in = dvi; d_ready = dr;
    a_param = 3'($urandom); a_size = 3'($urandom); a_mask = 4'($urandom);
    a_data = $urandom;
    d_opcode_in = 12'($urandom); d_param_in = 12'($urandom); d_size_in = 12'($urandom);
    d_source_in = 8'($urandom); d_sink_in = 4'($urandom); d_error_in = 4'($urandom);
    d_data_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Asserts reset immediately, checks the asynchronous reset values, and
  // releases away from the clock edge.
  task automatic doReset();
    reset = 1'b0;
    tgt_q.delete();
    m_err_cnt = 0;
    #1;
    checkOutput("rst_a_ready", a_ready, 1'b0);
    checkOutput("rst_a_valid_out", a_valid_out, '0);
    checkOutput("rst_d_valid", d_valid, 1'b0);
    checkOutput("rst_d_ready_in", d_ready_in, '0);
    checkOutput("rst_err_count", err_count, 16'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    // Reset with an unmapped request pending on A: a_ready must stay low.
    applyStimulus(1'b1, 3'd4, 32'h2000_0000, 2'd0, '1, '1, 1'b1);
    doReset();

    // Mapped Get to slave 2, then its AccessAckData.
    applyStimulus(1'b1, 3'd4, 32'h1000_2004, 2'd1, 4'b0100, '0, 1'b1);
    #1;
    checkOutput("get_s2_avo", a_valid_out, 4'b0100);
    stepCycle();
    applyStimulus(1'b0, 3'd4, 32'h1000_2004, 2'd1, 4'b0100, 4'b0100, 1'b1);
    d_data_in[2*32 +: 32] = 32'hDEAD_BEEF;
    d_source_in[2*2 +: 2] = 2'd1;
    d_error_in[2] = 1'b0;
    #1;
    checkOutput("get_s2_d_valid", d_valid, 1'b1);
    checkOutput("get_s2_d_data", d_data, 32'hDEAD_BEEF);
    checkOutput("get_s2_d_error", d_error, 1'b0);
    stepCycle();
    #1;
    checkOutput("get_s2_drained", d_valid, 1'b0);
    stepCycle();

    // Unmapped Get from source 3 goes to the error responder.
    applyStimulus(1'b1, 3'd4, 32'h2000_0000, 2'd3, '0, '0, 1'b0);
    #1;
    checkOutput("err_a_ready", a_ready, 1'b1);
    checkOutput("err_avo", a_valid_out, '0);
    stepCycle();
    applyStimulus(1'b0, 3'd0, 32'h0, 2'd0, '0, '0, 1'b0);
    #1;
    checkOutput("err_d_valid", d_valid, 1'b1);
    checkOutput("err_d_opcode", d_opcode, 3'd1);
    checkOutput("err_d_error", d_error, 1'b1);
    checkOutput("err_d_data", d_data, 32'h0);
    checkOutput("err_d_source", d_source, 2'd3);
    checkOutput("err_count1", err_count, 16'd1);
    stepCycle();
    d_ready = 1'b1;
    stepCycle();

    // PutFull to slave 0, then a Get to slave 1 must wait for the ack.
    applyStimulus(1'b1, 3'd0, 32'h1000_0010, 2'd0, '1, '0, 1'b1);
    stepCycle();
    applyStimulus(1'b1, 3'd4, 32'h1000_1000, 2'd2, '1, '0, 1'b1);
    #1;
    checkOutput("switch_blocked", a_ready, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 3'd4, 32'h1000_1000, 2'd2, '1, 4'b0001, 1'b1);
    #1;
    checkOutput("switch_same_cycle", a_ready, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 3'd4, 32'h1000_1000, 2'd2, '1, '0, 1'b1);
    #1;
    checkOutput("switch_next_cycle", a_ready, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 3'd4, 32'h1000_1000, 2'd2, '1, 4'b0010, 1'b1);
    stepCycle();

    // Five back-to-back Gets to slave 3 with d_ready low: fifth stalls.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 3'd4, 32'h1000_3000, 2'd0, '1, '0, 1'b0);
      #1;
      checkOutput("limit_a_ready", a_ready, (k < MAXO));
      stepCycle();
    end
    applyStimulus(1'b1, 3'd4, 32'h1000_3000, 2'd0, '1, 4'b1000, 1'b1);
    #1;
    checkOutput("limit_same_cycle", a_ready, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 3'd4, 32'h1000_3000, 2'd0, '1, '0, 1'b0);
    #1;
    checkOutput("limit_after_d", a_ready, 1'b1);
    stepCycle();
    for (int k = 0; k < MAXO; k++) begin
      applyStimulus(1'b0, 3'd4, 32'h1000_3000, 2'd0, '1, 4'b1000, 1'b1);
      stepCycle();
    end

    // Reset in the middle of a pending error response.
    applyStimulus(1'b1, 3'd4, 32'h3000_0000, 2'd2, '0, '0, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 3'd4, 32'h3000_0000, 2'd2, '0, '0, 1'b0);
    stepCycle();
    doReset();

    // Spurious valid from slave 1 while idle is ignored.
    applyStimulus(1'b0, 3'd4, 32'h1000_0000, 2'd0, '0, 4'b0010, 1'b1);
    #1;
    checkOutput("spurious_d_valid", d_valid, 1'b0);
    checkOutput("spurious_d_ready_in", d_ready_in, '0);
    stepCycle();

    // A mapped Get completes normally after reset.
    applyStimulus(1'b1, 3'd4, 32'h1000_1010, 2'd1, '1, '0, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 3'd4, 32'h1000_1010, 2'd1, '1, 4'b0010, 1'b1);
    #1;
    checkOutput("post_rst_d_valid", d_valid, 1'b1);
    stepCycle();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      int r;
      logic [31:0] addr;
      r = $urandom_range(0, 9);
      if (r < 7)      addr = base_tab[$urandom_range(0, N-1)] | 32'($urandom_range(0, 4095));
      else if (r < 9) addr = $urandom;
      else            addr = 32'h1000_4000;
      applyStimulus(1'($urandom_range(0, 3) != 0), 3'($urandom), addr, 2'($urandom),
                    4'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 499) == 0) doReset();
      else stepCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
